// File: rtl/div_unit_pkg.sv
// Shared types and constants for the iterative 32-bit divider.
package div_unit_pkg;

  localparam int DIV_W    = 32;
  localparam int DIV_ITER = 32;
  localparam int CNT_W    = $clog2(DIV_ITER);
  localparam int PR_W     = 2 * DIV_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } div_state_e;

  typedef struct packed {
    logic [DIV_W-1:0] hi;  // remainder
    logic [DIV_W-1:0] lo;  // quotient
  } div_result_t;

  function automatic logic [DIV_W-1:0] cond_neg(input logic [DIV_W-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/div_unit_step.sv
// One combinational restoring shift-subtract step on the {remainder, quotient} register.
module div_unit_step
  import div_unit_pkg::*;
(
  input  logic [PR_W-1:0]  pr_i,
  input  logic [DIV_W-1:0] divisor_i,
  output logic [PR_W-1:0]  pr_o,
  output logic             q_bit_o
);

  logic [DIV_W:0]   upper;
  logic [DIV_W+1:0] diff;
  logic             unused_msb;

  // The top bit is always zero after a step; the shift moves bit 63 into the trial remainder.
  assign unused_msb = pr_i[PR_W-1];

  always_comb begin
    upper   = pr_i[PR_W-2:DIV_W-1];
    diff    = {1'b0, upper} - {2'b00, divisor_i};
    q_bit_o = ~diff[DIV_W+1];
    pr_o    = {(q_bit_o ? diff[DIV_W:0] : upper), pr_i[DIV_W-2:0], q_bit_o};
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle DIV/DIVU unit: IDLE -> 32 BUSY iterations -> DONE held while the pipe is stalled.
// Build option DIV_ZERO_FAST_EN: a zero divisor skips the iteration and finishes next cycle.
module div_unit
  import div_unit_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 div_start,
  input  logic                 div_signed,
  input  logic [DIV_W-1:0]     opdata1,
  input  logic [DIV_W-1:0]     opdata2,
  input  logic                 annul,
  input  logic                 pipe_stall,
  output logic                 div_stall,
  output logic [2*DIV_W-1:0]   result,
  output logic                 result_valid
);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PR_W-1:0]  pr_q, pr_d;
  logic [DIV_W-1:0] divisor_q, divisor_d;
  logic             neg_q_q, neg_q_d;
  logic             neg_r_q, neg_r_d;
  div_result_t      result_q, result_d;

  logic [PR_W-1:0]  step_pr;
  logic             step_q_bit;
  logic             neg_a, neg_b;

  div_unit_step u_step (
    .pr_i      (pr_q),
    .divisor_i (divisor_q),
    .pr_o      (step_pr),
    .q_bit_o   (step_q_bit)
  );

  assign neg_a = div_signed & opdata1[DIV_W-1];
  assign neg_b = div_signed & opdata2[DIV_W-1];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pr_d      = pr_q;
    divisor_d = divisor_q;
    neg_q_d   = neg_q_q;
    neg_r_d   = neg_r_q;
    result_d  = result_q;

    if (annul) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (div_start) begin
            pr_d      = {{(DIV_W+1){1'b0}}, cond_neg(opdata1, neg_a)};
            divisor_d = cond_neg(opdata2, neg_b);
            neg_q_d   = neg_a ^ neg_b;
            neg_r_d   = neg_a;
            cnt_d     = '0;
            state_d   = ST_BUSY;
`ifdef DIV_ZERO_FAST_EN
            if (opdata2 == '0) begin
              state_d     = ST_DONE;
              result_d.hi = opdata1;
              result_d.lo = '1;
            end
`endif
          end
        end
        ST_BUSY: begin
          pr_d  = step_pr;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(DIV_ITER - 1)) begin
            // Sign fix-up lands in the result register together with the last step.
            state_d     = ST_DONE;
            result_d.lo = cond_neg(step_pr[DIV_W-1:0], neg_q_q);
            result_d.hi = cond_neg(step_pr[2*DIV_W-1:DIV_W], neg_r_q);
          end
        end
        ST_DONE: begin
          if (!pipe_stall) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      pr_q      <= '0;
      divisor_q <= '0;
      neg_q_q   <= 1'b0;
      neg_r_q   <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pr_q      <= pr_d;
      divisor_q <= divisor_d;
      neg_q_q   <= neg_q_d;
      neg_r_q   <= neg_r_d;
      result_q  <= result_d;
    end
  end

  // The quotient bit is already folded into step_pr; it is kept on the step port for clarity.
  logic unused_qbit;
  assign unused_qbit = step_q_bit;

  assign div_stall    = div_start & (state_q != ST_DONE) & ~annul & ~rst;
  assign result       = result_q;
  assign result_valid = (state_q == ST_DONE);

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit: latency, signed fix-up, annul, pipe_stall, reset.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        div_start;
  logic        div_signed;
  logic [31:0] opdata1;
  logic [31:0] opdata2;
  logic        annul;
  logic        pipe_stall;
  logic        div_stall;
  logic [63:0] result;
  logic        result_valid;

  int errors = 0;
  int checks = 0;

  div_unit dut (
    .clk          (clk),
    .rst          (rst),
    .div_start    (div_start),
    .div_signed   (div_signed),
    .opdata1      (opdata1),
    .opdata2      (opdata2),
    .annul        (annul),
    .pipe_stall   (pipe_stall),
    .div_stall    (div_stall),
    .result       (result),
    .result_valid (result_valid)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Start in the current cycle, scramble operands once busy, stop in the first DONE cycle.
  task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp, input int lat);
    div_start  = 1'b1;
    div_signed = sgn;
    opdata1    = a;
    opdata2    = b;
    #1;
    chk({tag, " start flags"}, {62'd0, div_stall, result_valid}, 64'h2);
    for (int k = 1; k < lat; k++) begin
      cyc();
      if (k == 1) begin
        opdata1    = ~a;
        opdata2    = b ^ 32'h5;
        div_signed = ~sgn;
      end
      chk({tag, " busy flags"}, {62'd0, div_stall, result_valid}, 64'h2);
    end
    cyc();
    chk({tag, " done flags"}, {62'd0, div_stall, result_valid}, 64'h1);
    chk({tag, " result"}, result, exp);
  endtask

  task automatic release_div(input string tag, input logic [63:0] exp);
    div_start  = 1'b0;
    pipe_stall = 1'b0;
    cyc();
    chk({tag, " idle flags"}, {62'd0, div_stall, result_valid}, 64'h0);
    chk({tag, " result held"}, result, exp);
  endtask

  initial begin
    rst        = 1'b1;
    div_start  = 1'b0;
    div_signed = 1'b0;
    opdata1    = '0;
    opdata2    = '0;
    annul      = 1'b0;
    pipe_stall = 1'b0;
    cyc();
    cyc();
    chk("reset flags", {62'd0, div_stall, result_valid}, 64'h0);
    chk("reset result", result, 64'h0);
    rst = 1'b0;
    cyc();
    chk("post reset idle", {62'd0, div_stall, result_valid}, 64'h0);

    run_div("u100/7", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 33);
    release_div("u100/7", 64'h00000002_0000000E);

    // pipe_stall raised throughout: must not slow BUSY, then holds DONE for 5 cycles
    pipe_stall = 1'b1;
    run_div("s-7/2", 1'b1, 32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFF_FFFFFFFD, 33);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("pstall valid", {63'd0, result_valid}, 64'h1);
      chk("pstall result", result, 64'hFFFFFFFF_FFFFFFFD);
    end
    pipe_stall = 1'b0;
    div_start  = 1'b0;
    cyc();
    cyc();
    chk("pstall released idle", {62'd0, div_stall, result_valid}, 64'h0);
    chk("pstall released hold", result, 64'hFFFFFFFF_FFFFFFFD);

    run_div("s min/-1", 1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 33);
    release_div("s min/-1", 64'h00000000_80000000);
    run_div("s7/-2", 1'b1, 32'h00000007, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 33);
    release_div("s7/-2", 64'h00000001_FFFFFFFD);
    run_div("s-7/-2", 1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, 64'hFFFFFFFF_00000003, 33);
    release_div("s-7/-2", 64'hFFFFFFFF_00000003);

    // annul in BUSY cycle 10
    div_start  = 1'b1;
    div_signed = 1'b0;
    opdata1    = 32'd1000;
    opdata2    = 32'd3;
    for (int i = 0; i < 10; i++) cyc();
    annul = 1'b1;
    #1;
    chk("annul stall", {62'd0, div_stall, result_valid}, 64'h0);
    cyc();
    annul     = 1'b0;
    div_start = 1'b0;
    chk("annul idle", {62'd0, div_stall, result_valid}, 64'h0);
    chk("annul result held", result, 64'hFFFFFFFF_00000003);
    for (int i = 0; i < 25; i++) begin
      cyc();
      chk("annul never valid", {63'd0, result_valid}, 64'h0);
    end
    run_div("restart", 1'b0, 32'hFFFFFFFF, 32'h00000010, 64'h0000000F_0FFFFFFF, 33);
    release_div("restart", 64'h0000000F_0FFFFFFF);

`ifdef DIV_ZERO_FAST_EN
    run_div("div0", 1'b0, 32'h12345678, 32'h0, 64'h12345678_FFFFFFFF, 1);
`else
    run_div("div0", 1'b0, 32'h12345678, 32'h0, 64'h12345678_FFFFFFFF, 33);
`endif
    release_div("div0", 64'h12345678_FFFFFFFF);

    // reset mid-divide at BUSY cycle 20
    div_start  = 1'b1;
    div_signed = 1'b0;
    opdata1    = 32'd50;
    opdata2    = 32'd5;
    for (int i = 0; i < 20; i++) cyc();
    rst       = 1'b1;
    div_start = 1'b0;
    cyc();
    chk("rst mid flags", {62'd0, div_stall, result_valid}, 64'h0);
    chk("rst mid result", result, 64'h0);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      chk("rst mid stays idle", {62'd0, div_stall, result_valid}, 64'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have port clk, input, 1: sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-003 SHALL have port div_start, input, 1: DIV/DIVU present in E stage.
REQ-004 SHALL have port div_signed, input, 1: 1 = DIV (signed), 0 = DIVU.
REQ-005 SHALL have port opdata1, input, 32: dividend (rs value, post-forwarding).
REQ-006 SHALL have port opdata2, input, 32: divisor (rt value, post-forwarding).
REQ-007 SHALL have port annul, input, 1: abort the in-flight divide (exception or flush).
REQ-008 SHALL have port pipe_stall, input, 1: E stage frozen by another source (includes SRAM stall).
REQ-009 SHALL have port div_stall, output, 1: request to the hazard unit to stall F/D/E/M/W.
REQ-010 SHALL have port result, output, 64: {hi = remainder, lo = quotient}.
REQ-011 SHALL have port result_valid, output, 1: result holds the final value.

Function
REQ-012 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-013 IDLE: div_start=1 and annul=0 SHALL latch |opdata1|, |opdata2|, sign flags and div_signed; go to BUSY; clear counter.
REQ-014 BUSY SHALL perform one restoring shift-subtract step per cycle on a 65-bit partial remainder, for exactly 32 cycles (counter 0..31).
REQ-015 Counter value 31 SHALL move the FSM to DONE on the next edge; result SHALL be valid from the first DONE cycle, 33 cycles after the start cycle.
REQ-016 Signed fix-up SHALL be applied on entry to DONE: quotient negated if operand signs differ; remainder takes the dividend's sign.
REQ-017 0x80000000 / 0xFFFFFFFF signed SHALL give q=0x80000000, r=0 (32-bit wrap, no trap).
REQ-018 div_stall SHALL equal div_start AND (state != DONE) AND NOT annul.
REQ-019 DONE SHALL hold result and result_valid=1 while pipe_stall=1, then return to IDLE on the first cycle with pipe_stall=0.
REQ-020 Outside DONE, result_valid SHALL be 0 and result SHALL hold its last value.
REQ-021 annul=1 in any state SHALL return the FSM to IDLE on the next edge and discard partial results; annul has priority over div_start.
REQ-022 Operands SHALL be sampled only in IDLE; input changes during BUSY SHALL be ignored.
REQ-023 pipe_stall SHALL NOT pause BUSY iteration.

Reset
REQ-024 rst=1 SHALL force state=IDLE, counter=0, result=0, result_valid=0, div_stall=0, including mid-divide.

Configuration
REQ-025 Macro DIV_ZERO_FAST_EN SHALL control divide-by-zero handling.
- Defined: divisor=0 in IDLE goes directly to DONE next cycle with result={opdata1, 32'hFFFFFFFF}, skipping the iteration.
- Undefined: divisor=0 runs the normal 32-cycle iteration.
- In both cases the result is architecturally undefined and no exception is raised.

Structure
REQ-026 A shared package SHALL hold: the FSM state encoding; DIV_W=32; DIV_ITER=32; the 64-bit result type.
REQ-027 An optional sub-module div_step (one combinational restoring step: 65-bit in, 65-bit out, quotient bit) MAY be used; all sequencing stays in div_unit.

Verification
REQ-028 Unsigned 100/7: start at cycle 0 -> div_stall=1 for cycles 0..32, result_valid at cycle 33, result={0x00000002, 0x0000000E}.
REQ-029 Signed -7/2 (0xFFFFFFF9/0x00000002) -> result={0xFFFFFFFF, 0xFFFFFFFD} after 33 cycles.
REQ-030 annul at cycle 10 of BUSY -> IDLE at cycle 11, div_stall=0, result_valid never asserted; a following start restarts the full 33-cycle latency.
REQ-031 pipe_stall high 5 cycles upon DONE -> result_valid and result stable for 5 cycles, IDLE on the 6th.
REQ-032 0x12345678/0 -> with DIV_ZERO_FAST_EN, result_valid next cycle, result={0x12345678, 0xFFFFFFFF}; without it, valid after 33 cycles.
REQ-033 rst pulsed at BUSY cycle 20 -> all outputs 0 and state=IDLE on the following cycle.
